// File: rtl/xalu_pkg.sv
// Shared MDU definitions: op encodings, FSM state encoding and op classification helpers.
// Reused by the E-stage controller and by the xalu_mdu datapath.
package xalu_pkg;

  localparam logic [3:0] XALU_OP_MULT  = 4'd1;
  localparam logic [3:0] XALU_OP_MULTU = 4'd2;
  localparam logic [3:0] XALU_OP_DIV   = 4'd3;
  localparam logic [3:0] XALU_OP_DIVU  = 4'd4;
  localparam logic [3:0] XALU_OP_MADD  = 4'd5;
  localparam logic [3:0] XALU_OP_MADDU = 4'd6;
  localparam logic [3:0] XALU_OP_MSUB  = 4'd7;
  localparam logic [3:0] XALU_OP_MSUBU = 4'd8;

  // Wide enough for the longest legal latency of 64 cycles.
  localparam int XALU_CNT_W = $clog2(64) + 1;

  typedef enum logic {
    XALU_ST_IDLE = 1'b0,
    XALU_ST_RUN  = 1'b1
  } xalu_state_t;

  function automatic logic xalu_op_legal(input logic [3:0] op);
    return (op >= XALU_OP_MULT) && (op <= XALU_OP_MSUBU);
  endfunction

  function automatic logic xalu_op_is_div(input logic [3:0] op);
    return (op == XALU_OP_DIV) || (op == XALU_OP_DIVU);
  endfunction

endpackage

// File: rtl/xalu_mdu_if.sv
// Issue/result bundle between the E-stage controller (master) and the MDU (slave).
// XALU_DIVZERO_FLAG_EN adds the sticky div_zero status signal.
interface xalu_mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef XALU_DIVZERO_FLAG_EN
  logic             div_zero;

  modport master (output start, op, a, b, hi_we, lo_we, wdata, flush,
                  input  busy, done, hi, lo, div_zero);
  modport slave  (input  start, op, a, b, hi_we, lo_we, wdata, flush,
                  output busy, done, hi, lo, div_zero);
`else
  modport master (output start, op, a, b, hi_we, lo_we, wdata, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we, wdata, flush,
                  output busy, done, hi, lo);
`endif
endinterface

// File: rtl/xalu_core.sv
// Combinational MDU datapath: product, quotient/remainder and HI/LO accumulate,
// evaluated on the latched operands and the current HI/LO.
module xalu_core
  import xalu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_we
);
  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    prod_s, prod_u, acc, res;
  logic [WIDTH-1:0] a_mag, b_mag, bs_safe, bu_safe;
  logic [WIDTH-1:0] qs_mag, rs_mag, qu, ru;
  logic             b_zero, q_neg;

  // NOTE: every output and temporary gets a default first, so no path leaves a latch behind.
  always_comb begin
    prod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc     = {hi, lo};
    b_zero  = (b == '0);

    // Signed divide on magnitudes keeps most-negative / -1 well defined.
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;
    bs_safe = b_zero ? WIDTH'(1) : b_mag;
    bu_safe = b_zero ? WIDTH'(1) : b;
    qs_mag  = a_mag / bs_safe;
    rs_mag  = a_mag % bs_safe;
    qu      = a / bu_safe;
    ru      = a % bu_safe;
    q_neg   = a[WIDTH-1] ^ b[WIDTH-1];

    res     = acc;
    res_we  = 1'b1;
    case (op)
      XALU_OP_MULT:  res = prod_s;
      XALU_OP_MULTU: res = prod_u;
      XALU_OP_MADD:  res = acc + prod_s;
      XALU_OP_MADDU: res = acc + prod_u;
      XALU_OP_MSUB:  res = acc - prod_s;
      XALU_OP_MSUBU: res = acc - prod_u;
      XALU_OP_DIV: begin
        if (b_zero) res_we = 1'b0;
        else res = {(a[WIDTH-1] ? -rs_mag : rs_mag), (q_neg ? -qs_mag : qs_mag)};
      end
      XALU_OP_DIVU: begin
        if (b_zero) res_we = 1'b0;
        else res = {ru, qu};
      end
      default: res_we = 1'b0;
    endcase
    res_hi = res[W2-1:WIDTH];
    res_lo = res[WIDTH-1:0];
  end

endmodule

// File: rtl/xalu_mdu.sv
// Multi-cycle multiply/divide unit: IDLE/RUN FSM, latency counter and HI/LO registers.
// XALU_DIVZERO_FLAG_EN adds a sticky div_zero flag for divides by zero.
module xalu_mdu
  import xalu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  xalu_mdu_if.slave  bus
);
  localparam logic [XALU_CNT_W-1:0] MULT_LOAD = XALU_CNT_W'(MULT_CYCLES - 1);
  localparam logic [XALU_CNT_W-1:0] DIV_LOAD  = XALU_CNT_W'(DIV_CYCLES - 1);

  xalu_state_t           state;
  logic [XALU_CNT_W-1:0] cnt;
  logic [3:0]            op_q;
  logic [WIDTH-1:0]      a_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0]      res_hi, res_lo;
  logic                  res_we, done_q, accept, commit;

  assign accept = (state == XALU_ST_IDLE) && bus.start && !bus.flush && xalu_op_legal(bus.op);
  assign commit = (state == XALU_ST_RUN) && !bus.flush && (cnt == '0);

  // NOTE: the operand latches carry no reset; they are only consumed in RUN, which needs a fresh accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.op;
      a_q  <= bus.a;
      b_q  <= bus.b;
    end
  end

  xalu_core #(.WIDTH(WIDTH)) core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .res_we (res_we)
  );

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= XALU_ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        XALU_ST_IDLE: begin
          if (accept) begin
            state <= XALU_ST_RUN;
            cnt   <= xalu_op_is_div(bus.op) ? DIV_LOAD : MULT_LOAD;
          end else begin
            // mthi/mtlo only land when no start is taken in the same cycle.
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        XALU_ST_RUN: begin
          if (bus.flush) begin
            state <= XALU_ST_IDLE;
            cnt   <= '0;
          end else if (commit) begin
            state  <= XALU_ST_IDLE;
            done_q <= 1'b1;
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt <= cnt - XALU_CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == XALU_ST_RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

`ifdef XALU_DIVZERO_FLAG_EN
  logic dz_q;

  always_ff @(posedge clk) begin
    if (reset || accept) dz_q <= 1'b0;
    else if (commit && xalu_op_is_div(op_q) && (b_q == '0)) dz_q <= 1'b1;
  end

  assign bus.div_zero = dz_q;
`endif

endmodule

// File: tb/tb_xalu_mdu.sv
// Self-checking bench for xalu_mdu: directed spec scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a 64-bit arithmetic reference model.
module tb_xalu_mdu;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xalu_mdu_if #(.WIDTH(W)) bus ();

  xalu_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo, p_a, p_b;
  logic [3:0]  p_op;
  bit          m_busy, m_done, m_dz;
  int          m_left;

  task automatic model_commit();
    logic [63:0] acc, ps, pu;
    longint      sq, sr;
    acc = {m_hi, m_lo};
    ps  = 64'(longint'($signed(p_a)) * longint'($signed(p_b)));
    pu  = 64'(p_a) * 64'(p_b);
    case (p_op)
      4'd1: acc = ps;
      4'd2: acc = pu;
      4'd5: acc = acc + ps;
      4'd6: acc = acc + pu;
      4'd7: acc = acc - ps;
      4'd8: acc = acc - pu;
      4'd3: begin
        if (p_b == 0) m_dz = 1'b1;
        else begin
          sq  = longint'($signed(p_a)) / longint'($signed(p_b));
          sr  = longint'($signed(p_a)) % longint'($signed(p_b));
          acc = {sr[31:0], sq[31:0]};
        end
      end
      4'd4: begin
        if (p_b == 0) m_dz = 1'b1;
        else acc = {p_a % p_b, p_a / p_b};
      end
      default: ;
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bus.flush) m_busy = 1'b0;
        else if (m_left == 1) begin
          model_commit();
          m_busy = 1'b0;
          m_done = 1'b1;
        end else m_left--;
      end else if (bus.start && !bus.flush && bus.op >= 1 && bus.op <= 8) begin
        p_op   = bus.op;
        p_a    = bus.a;
        p_b    = bus.b;
        m_left = (bus.op == 3 || bus.op == 4) ? DC : MC;
        m_busy = 1'b1;
        m_dz   = 1'b0;
      end else begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 64'(bus.busy), 64'(m_busy));
      check("model_done", 64'(bus.done), 64'(m_done));
      check("model_hi", 64'(bus.hi), 64'(m_hi));
      check("model_lo", 64'(bus.lo), 64'(m_lo));
`ifdef XALU_DIVZERO_FLAG_EN
      check("model_div_zero", 64'(bus.div_zero), 64'(m_dz));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    launch(op, a, b);
    check({name, "_accepted"}, 64'(bus.busy), 64'd1);
    wait_done(lat);
  endtask

  task automatic write_hl(input logic [31:0] hv, input logic [31:0] lv);
    bus.hi_we = 1'b1; bus.wdata = hv; tick(); bus.hi_we = 1'b0;
    bus.lo_we = 1'b1; bus.wdata = lv; tick(); bus.lo_we = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom % 8);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  saw_done;
    logic [3:0] ill_ops [3];
    ill_ops = '{4'd0, 4'd9, 4'd15};

    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);

    // signed multiply and latency
    do_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, lat);
    check("mult_latency", 64'(lat), 64'(MC));
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

    // accumulate and unsigned subtract with wrap
    write_hl(32'd0, 32'd10);
    do_op("madd", 4'd5, 32'd2, 32'd3, lat);
    check("madd_hi", 64'(bus.hi), 64'd0);
    check("madd_lo", 64'(bus.lo), 64'd16);
    do_op("msubu", 4'd8, 32'd4, 32'd5, lat);
    check("msubu_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFC);

    // signed divide
    do_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_latency", 64'(lat), 64'(DC));
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    // divide by zero leaves HI/LO but still completes
    write_hl(32'd1, 32'd2);
    do_op("divu0", 4'd4, 32'd7, 32'd0, lat);
    check("divu0_latency", 64'(lat), 64'(DC));
    check("divu0_done", 64'(bus.done), 64'd1);
    check("divu0_hilo", {bus.hi, bus.lo}, {32'd1, 32'd2});
`ifdef XALU_DIVZERO_FLAG_EN
    check("divu0_flag", 64'(bus.div_zero), 64'd1);
`endif

    // most-negative / -1
    do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_hilo", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
`ifdef XALU_DIVZERO_FLAG_EN
    check("div_ovf_flag_clr", 64'(bus.div_zero), 64'd0);
`endif

    // flush in cycle 3
    write_hl(32'h11, 32'h22);
    launch(4'd1, 32'd9, 32'd9);
    repeat (2) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_c4_busy", 64'(bus.busy), 64'd0);
    saw_done = bus.done;
    repeat (6) begin
      tick();
      saw_done |= bus.done;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});

    // flush on the commit edge
    launch(4'd1, 32'd9, 32'd9);
    repeat (MC - 1) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_commit_done", 64'(bus.done), 64'd0);
    check("flush_commit_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});

    // start beats mthi in the same idle cycle
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    launch(4'd1, 32'd3, 32'd4);
    bus.hi_we = 1'b0;
    check("start_win_hi_held", 64'(bus.hi), 64'h11);
    wait_done(lat);
    check("start_win_hilo", {bus.hi, bus.lo}, {32'd0, 32'd12});

    // mthi/mtlo while busy are dropped
    launch(4'd1, 32'd5, 32'd6);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
    repeat (3) tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    wait_done(lat);
    check("busy_we_hilo", {bus.hi, bus.lo}, {32'd0, 32'd30});

    // back-to-back issue in the done cycle
    do_op("b2b_first", 4'd2, 32'd1, 32'd7, lat);
    check("b2b_first_lo", 64'(bus.lo), 64'd7);
    do_op("b2b_second", 4'd5, 32'd2, 32'd2, lat);
    check("b2b_latency", 64'(lat), 64'(MC));
    check("b2b_lo", 64'(bus.lo), 64'd11);

    // illegal ops and start under flush are ignored
    foreach (ill_ops[i]) begin
      launch(ill_ops[i], 32'd1, 32'd1);
      check("illegal_op_busy", 64'(bus.busy), 64'd0);
    end
    bus.flush = 1'b1;
    launch(4'd1, 32'd1, 32'd1);
    bus.flush = 1'b0;
    check("start_flush_busy", 64'(bus.busy), 64'd0);

    // reset mid-divide wins over everything else
    launch(4'd3, 32'd100, 32'd7);
    repeat (3) tick();
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 4'd1; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    bus.wdata = 32'h5A5A; bus.flush = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom % 3) == 0;
      bus.op    = (($urandom % 5) == 0) ? 4'($urandom % 16) : 4'(1 + $urandom % 8);
      bus.a     = pick();
      bus.b     = pick();
      bus.flush = ($urandom % 20) == 0;
      bus.hi_we = ($urandom % 8) == 0;
      bus.lo_we = ($urandom % 8) == 0;
      bus.wdata = pick();
      reset     = ($urandom % 400) == 0;
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (DC + 2) tick();
    check("final_idle", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xalu_mdu.md
XALU_MDU -- requirements
Module: xalu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for ops 1,2,5-8 (legal range 1..64).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for ops 3,4 (legal range 1..64).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to launch op with a/b.
REQ-007 op  input  4  1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu; 0 and 9-15 no-op.
REQ-008 a, b  input  WIDTH each  operands (rs, rt).
REQ-009 hi_we, lo_we  input  1 each  mthi / mtlo write strobes.
REQ-010 wdata  input  WIDTH  data for hi_we/lo_we.
REQ-011 flush  input  1  abort in-flight op.
REQ-012 busy  output  1  op in flight.
REQ-013 done  output  1  one-cycle pulse, result committed.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 start with legal op SHALL be accepted only when busy=0 and flush=0; otherwise ignored; illegal op ignored.
REQ-016 On acceptance at edge 0, a, b, op SHALL be latched; busy=1 for cycles 1..N (N = MULT_CYCLES or DIV_CYCLES); at the edge ending cycle N, HI/LO update; busy=0 and done=1 in cycle N+1.
REQ-017 A new start SHALL be acceptable in cycle N+1 (back-to-back, no bubble).
REQ-018 States: IDLE -> RUN (on accept) -> IDLE (count reaches N or flush); counter counts down from N-1, width clog2(64)+1.
REQ-019 mult: {HI,LO} = signed a*b, 2*WIDTH bits; multu: unsigned product.
REQ-020 madd/maddu: {HI,LO} += signed/unsigned product, modulo 2^(2*WIDTH); msub/msubu: {HI,LO} -= product, same wrap; accumulator value SHALL be HI/LO at commit edge.
REQ-021 div: LO = quotient truncated toward zero, HI = remainder with dividend sign; divu: unsigned.
REQ-022 div with b=0 (either signedness) SHALL leave HI/LO unchanged; done still pulses after DIV_CYCLES.
REQ-023 Signed div of most-negative by -1: LO = most-negative, HI = 0.
REQ-024 hi_we/lo_we SHALL write wdata to HI/LO only when busy=0; ignored while busy=1.
REQ-025 start accepted and hi_we/lo_we same cycle: start SHALL win, write dropped.
REQ-026 flush while busy: HI/LO unchanged, busy=0 next cycle, no done; flush coinciding with commit edge SHALL suppress the commit.
REQ-027 hi, lo SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-028 reset SHALL force hi=0, lo=0, busy=0, done=0, state IDLE, counter 0, regardless of in-flight op.
REQ-029 reset SHALL take priority over start, flush, hi_we, lo_we in the same cycle.

Configuration
REQ-030 Macro XALU_DIVZERO_FLAG_EN defined: SHALL add output div_zero (1 bit), set at the commit edge of a div/divu with b=0, sticky until reset or next accepted start.
REQ-031 Macro undefined: div_zero port SHALL not exist; REQ-022 behaviour unchanged.

Structure
REQ-032 Op encoding constants (XALU_OP_MULT..XALU_OP_MSUBU, values 1..8) and the state encoding SHALL live in shared package xalu_pkg, reused by the E-stage controller.
REQ-033 Datapath arithmetic (product, quotient/remainder, accumulate) SHALL be one sub-module xalu_core, combinational on latched operands; xalu_mdu holds FSM, counter, HI/LO.

Verification
REQ-034 mult a=0xFFFFFFFE b=3 (WIDTH=32, MULT_CYCLES=5) -> busy cycles 1..5, done cycle 6, HI=0xFFFFFFFF LO=0xFFFFFFFA.
REQ-035 mthi 0, mtlo 10, then madd a=2 b=3 -> LO=16 HI=0; then msubu a=4 b=5 -> {HI,LO}=0xFFFFFFFF_FFFFFFFC.
REQ-036 div a=-7 b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; divu a=7 b=0 after HI=1 LO=2 -> HI=1 LO=2, done pulses, div_zero=1 if XALU_DIVZERO_FLAG_EN.
REQ-037 start mult, flush in cycle 3 -> busy=0 cycle 4, no done, HI/LO unchanged; start plus hi_we same idle cycle -> HI from result, wdata dropped.
REQ-038 hi_we while busy -> ignored; reset asserted mid-div -> cycle after: hi=lo=0, busy=0, done=0; start in cycle N+1 accepted back-to-back.
